prog_sequencer: RTL and testbench

//  Parametrised program sequencer: next-generation fetch/run control for the 9-bit core.

---
 rtl/proc_pkg.sv | 12 +
 rtl/sat_counter.sv | 16 +
 rtl/prog_sequencer.sv | 92 +++++++++
 tb/tb_prog_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and default widths for the 9-bit core: sequencer state, halt opcode, bus widths.
package proc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  localparam int DEF_PCW  = 10;
  localparam int DEF_IW   = 9;
  localparam int DEF_OPW  = 4;
  localparam int DEF_OFFW = 6;
  localparam int DEF_CW   = 16;

  localparam logic [3:0] OP_HALT = 4'hD;
endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge Clk) begin
    if (!Reset)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/prog_sequencer.sv
// Fetch/run control for the 9-bit core: PC, Start/Ack handshake, branch select,
// stall hold, halt detect, cycle/retire counters and a run watchdog.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int            PCW     = DEF_PCW,
  parameter int            IW      = DEF_IW,
  parameter int            OPW     = DEF_OPW,
  parameter logic [OPW-1:0] HALT_OP = OPW'(OP_HALT),
  parameter int            OFFW    = DEF_OFFW,
  parameter int            CW      = DEF_CW,
  parameter logic [CW-1:0] MAXCYC  = {CW{1'b1}}
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PCW-1:0]  StartAddr,
  input  logic [IW-1:0]   Instruction,
  input  logic            Stall,
  input  logic            BranchAbs,
  input  logic            BranchRelEn,
  input  logic            Taken,
  input  logic [PCW-1:0]  Target,
  input  logic [OFFW-1:0] Offset,
  output logic [PCW-1:0]  ProgCtr,
  output logic            Running,
  output logic            Ack,
  output logic            Timeout,
  output logic [CW-1:0]   CycleCt,
  output logic [CW-1:0]   InstrCt
);
  seq_state_e     state, nextState;
  logic [PCW-1:0] nextPc, offExt;
  logic           nextTimeout, isHalt, wdHit, inRun;

  // Operand bits belong to Ctrl; only the opcode matters here.
  logic unusedOperand;
  assign unusedOperand = ^Instruction[IW-OPW-1:0];

  assign inRun   = (state == RUN);
  assign isHalt  = (Instruction[IW-1 -: OPW] == HALT_OP);
  assign wdHit   = (MAXCYC != '0) && (CycleCt == MAXCYC - CW'(1));
  assign offExt  = {{(PCW-OFFW){Offset[OFFW-1]}}, Offset};
  assign Running = inRun;
  assign Ack     = (state == DONE);

  always_comb begin
    nextState   = state;
    nextPc      = ProgCtr;
    nextTimeout = Timeout;
    if (Start) begin
      nextState   = RUN;
      nextPc      = StartAddr;
      nextTimeout = 1'b0;
    end else if (inRun) begin
      if (!Stall && isHalt) begin
        nextState = DONE;
      end else begin
        if (!Stall) begin
          if (BranchAbs)                nextPc = Target;
          else if (BranchRelEn && Taken) nextPc = ProgCtr + offExt;
          else                           nextPc = ProgCtr + PCW'(1);
        end
        // Halt in the same cycle took the branch above, so it wins over the watchdog.
        if (wdHit) begin
          nextState   = DONE;
          nextTimeout = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
      Timeout <= 1'b0;
    end else begin
      state   <= nextState;
      ProgCtr <= nextPc;
      Timeout <= nextTimeout;
    end
  end

  sat_counter #(.CW(CW)) uCycCt (
    .Clk(Clk), .Reset(Reset), .clr(Start), .en(inRun), .cnt(CycleCt)
  );

  sat_counter #(.CW(CW)) uInstrCt (
    .Clk(Clk), .Reset(Reset), .clr(Start), .en(inRun && !Stall), .cnt(InstrCt)
  );
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed scoreboard bench for prog_sequencer (watchdog limit set to 8 cycles).
module tb_prog_sequencer;
  import proc_pkg::*;

  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] HALT = 9'h1A0;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, BranchAbs, BranchRelEn, Taken;
  logic [9:0]  StartAddr, Target, ProgCtr;
  logic [8:0]  Instruction;
  logic [5:0]  Offset;
  logic        Running, Ack, Timeout;
  logic [15:0] CycleCt, InstrCt;

  always #5 Clk = ~Clk;

  prog_sequencer #(.MAXCYC(16'd8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Instruction(Instruction), .Stall(Stall), .BranchAbs(BranchAbs),
    .BranchRelEn(BranchRelEn), .Taken(Taken), .Target(Target), .Offset(Offset),
    .ProgCtr(ProgCtr), .Running(Running), .Ack(Ack), .Timeout(Timeout),
    .CycleCt(CycleCt), .InstrCt(InstrCt)
  );

  typedef struct {
    logic [9:0]  pc;
    logic        run, ack, to;
    logic [15:0] cyc;
    logic        chkIns;
    logic [15:0] ins;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  exp_t  mon;
  string monNm;
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  always @(posedge Clk) begin
    #1;
    if (expQ.size() > 0) begin
      mon   = expQ.pop_front();
      monNm = nameQ.pop_front();
      cmp(monNm, "ProgCtr", {6'd0, ProgCtr}, {6'd0, mon.pc});
      cmp(monNm, "Running", {15'd0, Running}, {15'd0, mon.run});
      cmp(monNm, "Ack",     {15'd0, Ack},     {15'd0, mon.ack});
      cmp(monNm, "Timeout", {15'd0, Timeout}, {15'd0, mon.to});
      cmp(monNm, "CycleCt", CycleCt, mon.cyc);
      if (mon.chkIns) cmp(monNm, "InstrCt", InstrCt, mon.ins);
    end
  end

  task automatic step(input string nm, input logic [9:0] pc, input logic run, input logic ack,
                      input logic to, input logic [15:0] cyc, input logic chkIns, input logic [15:0] ins);
    exp_t e;
    e.pc = pc; e.run = run; e.ack = ack; e.to = to; e.cyc = cyc; e.chkIns = chkIns; e.ins = ins;
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(posedge Clk);
    #2;
  endtask

  task automatic quiet();
    Start = 1'b0; Stall = 1'b0; BranchAbs = 1'b0; BranchRelEn = 1'b0; Taken = 1'b0;
    Instruction = NOP; Offset = '0; Target = '0;
  endtask

  initial begin
    quiet();
    Reset = 1'b0; Start = 1'b1; StartAddr = 10'h055;
    step("reset0", 10'h000, 0, 0, 0, 0, 1, 0);
    step("reset1", 10'h000, 0, 0, 0, 0, 1, 0);
    Reset = 1'b1; Start = 1'b0;
    step("idle", 10'h000, 0, 0, 0, 0, 1, 0);

    // straight line then halt
    Start = 1'b1; StartAddr = 10'h010;
    step("start10", 10'h010, 1, 0, 0, 0, 1, 0);
    Start = 1'b0;
    for (int i = 0; i < 5; i++)
      step("line", 10'(10'h011 + i), 1, 0, 0, 16'(i + 1), 1, 16'(i + 1));
    Instruction = HALT;
    step("halt", 10'h015, 0, 1, 0, 6, 1, 6);
    Instruction = NOP;
    step("donehold", 10'h015, 0, 1, 0, 6, 1, 6);

    // branches
    Start = 1'b1; StartAddr = 10'h003;
    step("start3", 10'h003, 1, 0, 0, 0, 1, 0);
    Start = 1'b0; BranchRelEn = 1'b1; Taken = 1'b1; Offset = 6'h3C;
    step("relwrap", 10'h3FF, 1, 0, 0, 1, 1, 1);
    Start = 1'b1; StartAddr = 10'h003; BranchRelEn = 1'b0; Taken = 1'b0;
    step("start3b", 10'h003, 1, 0, 0, 0, 1, 0);
    Start = 1'b0; BranchRelEn = 1'b1; Taken = 1'b1; Offset = 6'h3C; BranchAbs = 1'b1; Target = 10'h020;
    step("absprio", 10'h020, 1, 0, 0, 1, 1, 1);
    BranchAbs = 1'b0; Taken = 1'b0;
    step("nottaken", 10'h021, 1, 0, 0, 2, 1, 2);
    Taken = 1'b1; Offset = 6'd5;
    step("relpos", 10'h026, 1, 0, 0, 3, 1, 3);

    // stalls, halt opcode and branch ignored while stalled
    quiet(); Start = 1'b1; StartAddr = 10'h100;
    step("start100", 10'h100, 1, 0, 0, 0, 1, 0);
    Start = 1'b0;
    step("s1", 10'h101, 1, 0, 0, 1, 1, 1);
    Stall = 1'b1; BranchAbs = 1'b1; Target = 10'h2AA; Instruction = HALT;
    for (int i = 0; i < 3; i++)
      step("stall", 10'h101, 1, 0, 0, 16'(2 + i), 1, 1);
    quiet();
    step("unstall", 10'h102, 1, 0, 0, 5, 1, 2);
    Instruction = HALT;
    step("halt2", 10'h102, 0, 1, 0, 6, 1, 3);

    // watchdog on a tight loop
    quiet(); Start = 1'b1; StartAddr = 10'h040;
    step("start40", 10'h040, 1, 0, 0, 0, 1, 0);
    Start = 1'b0; BranchAbs = 1'b1; Target = 10'h040;
    for (int k = 1; k < 8; k++)
      step("loop", 10'h040, 1, 0, 0, 16'(k), 1, 16'(k));
    step("wdog", 10'h040, 0, 1, 1, 8, 0, 0);
    step("wdhold", 10'h040, 0, 1, 1, 8, 0, 0);

    // restarts
    quiet(); Start = 1'b1; StartAddr = 10'h200;
    step("restartDone", 10'h200, 1, 0, 0, 0, 1, 0);
    Start = 1'b0;
    step("r1", 10'h201, 1, 0, 0, 1, 1, 1);
    Start = 1'b1; StartAddr = 10'h300; BranchAbs = 1'b1; Target = 10'h111; Stall = 1'b1;
    step("restartRun", 10'h300, 1, 0, 0, 0, 1, 0);
    quiet();
    step("r2", 10'h301, 1, 0, 0, 1, 1, 1);
    Start = 1'b1; StartAddr = 10'h010; Instruction = HALT;
    step("restartHalt", 10'h010, 1, 0, 0, 0, 1, 0);
    quiet();
    step("r3", 10'h011, 1, 0, 0, 1, 1, 1);

    // halt on the watchdog cycle: halt wins
    Start = 1'b1; StartAddr = 10'h000;
    step("start0", 10'h000, 1, 0, 0, 0, 1, 0);
    Start = 1'b0;
    for (int k = 1; k < 8; k++)
      step("pre", 10'(k), 1, 0, 0, 16'(k), 1, 16'(k));
    Instruction = HALT;
    step("haltWins", 10'h007, 0, 1, 0, 8, 1, 8);

    // reset mid-program
    quiet(); Start = 1'b1; StartAddr = 10'h123;
    step("start123", 10'h123, 1, 0, 0, 0, 1, 0);
    Start = 1'b0;
    step("m1", 10'h124, 1, 0, 0, 1, 1, 1);
    Reset = 1'b0; Start = 1'b1;
    step("midReset", 10'h000, 0, 0, 0, 0, 1, 0);
    Reset = 1'b1; Start = 1'b0;

    @(posedge Clk); #2;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
